main_mem_ctrl: RTL and testbench

Word-addressed main-memory model and controller on the downstream side of the 2-way/8-way cache controller. It accepts single-word read and write requests over the rd/wr/ready handshake and holds an internal 32-bit word array. It stretches each access over a programmable number of wait cycles, then returns read data on the shared bidirectional data bus. It stands in for external SRAM in simulation and FPGA builds.

---
 rtl/main_mem_ctrl_if.sv | 30 +++
 rtl/main_mem_ctrl.sv | 100 ++++++++++
 tb/tb_main_mem_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/main_mem_ctrl_if.sv
// Cache-to-main-memory bus: rd/wr/ready handshake plus a shared tri-state data bus.
// Both bus drivers resolve here so each side only supplies its value and output enable.
interface main_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] addr_sram;
    logic              rd_sram;
    logic              wr_sram;
    logic              ready_sram;
    logic              err_sram;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_oe;
    logic [DATA_W-1:0] cache_wdata;
    logic              cache_oe;
    wire  [DATA_W-1:0] data_sram;

    assign data_sram = mem_oe   ? mem_rdata   : 'z;
    assign data_sram = cache_oe ? cache_wdata : 'z;

    modport master (
        output addr_sram, rd_sram, wr_sram, cache_wdata, cache_oe,
        input  ready_sram, err_sram, data_sram
    );

    modport slave (
        input  addr_sram, rd_sram, wr_sram, data_sram,
        output ready_sram, err_sram, mem_rdata, mem_oe
    );
endinterface

// File: rtl/main_mem_ctrl.sv
// Word-addressed main-memory model: each access takes LATENCY busy cycles, reads return on data_sram.
// Define MAIN_MEM_RW_ERR_EN to reject simultaneous rd/wr with a one-cycle err_sram pulse.
module main_mem_ctrl #(
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 4
) (
    input logic            clk,
    input logic            reset_n,
    main_mem_ctrl_if.slave bus
);
    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state;
    logic [7:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              op_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              drv_q;
    logic              ready_q;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              req;
    logic              rw_conflict;
    logic              mem_we;

    assign req = bus.rd_sram | bus.wr_sram;

`ifdef MAIN_MEM_RW_ERR_EN
    assign rw_conflict = bus.rd_sram & bus.wr_sram;
`else
    assign rw_conflict = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= StIdle;
            cnt     <= '0;
            addr_q  <= '0;
            op_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            drv_q   <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (req) begin
                        if (rw_conflict) begin
                            err_q <= 1'b1;
                        end else begin
                            // Write wins when both requests are high.
                            addr_q  <= bus.addr_sram;
                            op_q    <= bus.wr_sram;
                            if (bus.wr_sram) wdata_q <= bus.data_sram;
                            cnt     <= CNT_INIT;
                            drv_q   <= 1'b0;
                            ready_q <= 1'b0;
                            state   <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        if (!op_q) begin
                            rdata_q <= mem[addr_q];
                            drv_q   <= 1'b1;
                        end
                        ready_q <= 1'b1;
                        state   <= StDone;
                    end
                end
                StDone: begin
                    if (!req) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // The array is never reset; an async reset mid-access leaves StBusy before the commit edge.
    assign mem_we = (state == StBusy) && (cnt == 8'd0) && op_q;

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= wdata_q;
    end

    assign bus.ready_sram = ready_q;
    assign bus.err_sram   = err_q;
    assign bus.mem_rdata  = rdata_q;
    assign bus.mem_oe     = drv_q & ~bus.wr_sram;
endmodule

// File: tb/tb_main_mem_ctrl.sv
// Scoreboard bench for main_mem_ctrl: one LATENCY=3 instance and one LATENCY=1 instance.
module tb_main_mem_ctrl;
    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] exp_q[$];
    bit   [31:0] model [int];

    main_mem_ctrl_if #(.ADDR_W(17), .DATA_W(32)) bus3 ();
    main_mem_ctrl_if #(.ADDR_W(17), .DATA_W(32)) bus1 ();

    main_mem_ctrl #(.ADDR_W(17), .DATA_W(32), .LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(bus3)
    );
    main_mem_ctrl #(.ADDR_W(17), .DATA_W(32), .LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, want finish before timeout");
        $fatal(1);
    end

    function automatic int key(input bit fast, input logic [16:0] a);
        return fast ? int'(a) + 32'h0010_0000 : int'(a);
    endfunction

    task automatic drive(input bit fast, input bit rd, input bit wr, input logic [16:0] a,
                         input logic [31:0] d);
        if (fast) begin
            bus1.addr_sram = a; bus1.rd_sram = rd; bus1.wr_sram = wr;
            bus1.cache_wdata = d; bus1.cache_oe = wr;
        end else begin
            bus3.addr_sram = a; bus3.rd_sram = rd; bus3.wr_sram = wr;
            bus3.cache_wdata = d; bus3.cache_oe = wr;
        end
    endtask

    task automatic start(input bit fast, input bit wr, input logic [16:0] a, input logic [31:0] d);
        @(negedge clk);
        drive(fast, !wr, wr, a, d);
        if (!wr) exp_q.push_back(model.exists(key(fast, a)) ? model[key(fast, a)] : 32'h0);
    endtask

    task automatic finish(input bit fast, input bit wr, input logic [16:0] a, input logic [31:0] d,
                          output int low);
        low = 0;
        @(negedge clk);
        while ((fast ? bus1.ready_sram : bus3.ready_sram) !== 1'b1 && low < 50) begin
            low++;
            @(negedge clk);
        end
        if (wr) model[key(fast, a)] = d;
    endtask

    task automatic release_req(input bit fast);
        drive(fast, 1'b0, 1'b0, 17'h0, 32'h0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 17'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 17'h0, 32'h0);
        repeat (2) @(negedge clk);
        checks++; if (bus3.ready_sram !== 1'b1) begin errors++;
            $display("FAIL reset_ready: got %b want 1", bus3.ready_sram); end
        checks++; if (bus3.err_sram !== 1'b0) begin errors++;
            $display("FAIL reset_err: got %b want 0", bus3.err_sram); end
        checks++; if (bus3.mem_oe !== 1'b0) begin errors++;
            $display("FAIL reset_bus_z: drive enable got %b want 0", bus3.mem_oe); end
        checks++; if (bus1.ready_sram !== 1'b1) begin errors++;
            $display("FAIL reset_ready_fast: got %b want 1", bus1.ready_sram); end
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (bus3.ready_sram !== 1'b1 || bus3.err_sram !== 1'b0) begin errors++;
                $display("FAIL idle_ready cycle %0d: got ready=%b err=%b want 1/0",
                         i, bus3.ready_sram, bus3.err_sram); end
        end
    endtask

    task automatic test_write_read();
        int low;
        logic [31:0] exp;
        start(1'b0, 1'b1, 17'h00123, 32'hDEADBEEF);
        #1;
        checks++; if (bus3.mem_oe !== 1'b0) begin errors++;
            $display("FAIL wr_no_drive: drive enable got %b want 0", bus3.mem_oe); end
        finish(1'b0, 1'b1, 17'h00123, 32'hDEADBEEF, low);
        checks++; if (low !== 3) begin errors++;
            $display("FAIL wr_latency: ready low %0d cycles want 3", low); end
        release_req(1'b0);
        start(1'b0, 1'b0, 17'h00123, 32'h0);
        finish(1'b0, 1'b0, 17'h00123, 32'h0, low);
        exp = exp_q.pop_front();
        checks++; if (low !== 3) begin errors++;
            $display("FAIL rd_latency: ready low %0d cycles want 3", low); end
        checks++; if (bus3.data_sram !== exp) begin errors++;
            $display("FAIL rd_data: got %h want %h", bus3.data_sram, exp); end
        release_req(1'b0);
        repeat (3) @(negedge clk);
        checks++; if (bus3.data_sram !== exp || bus3.mem_oe !== 1'b1) begin errors++;
            $display("FAIL rd_data_held: got %h oe=%b want %h oe=1", bus3.data_sram, bus3.mem_oe,
                     exp); end
    endtask

    task automatic test_hold();
        int low;
        logic [31:0] exp;
        start(1'b0, 1'b0, 17'h00123, 32'h0);
        finish(1'b0, 1'b0, 17'h00123, 32'h0, low);
        exp = exp_q.pop_front();
        checks++; if (low !== 3) begin errors++;
            $display("FAIL hold_latency: ready low %0d cycles want 3", low); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (bus3.ready_sram !== 1'b1 || bus3.data_sram !== exp) begin errors++;
                $display("FAIL hold_single_access cycle %0d: got ready=%b data=%h want 1/%h",
                         i, bus3.ready_sram, bus3.data_sram, exp); end
        end
        release_req(1'b0);
        checks++; if (bus3.ready_sram !== 1'b1) begin errors++;
            $display("FAIL hold_release: ready got %b want 1", bus3.ready_sram); end
    endtask

    task automatic test_reset_busy();
        int low;
        logic [31:0] exp;
        start(1'b0, 1'b1, 17'h1FFFF, 32'h0);
        finish(1'b0, 1'b1, 17'h1FFFF, 32'h0, low);
        release_req(1'b0);
        start(1'b0, 1'b1, 17'h1FFFF, 32'h11111111);
        repeat (2) @(negedge clk);
        checks++; if (bus3.ready_sram !== 1'b0) begin errors++;
            $display("FAIL rst_busy_pre: ready got %b want 0", bus3.ready_sram); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus3.ready_sram !== 1'b1) begin errors++;
            $display("FAIL rst_async_ready: got %b want 1", bus3.ready_sram); end
        drive(1'b0, 1'b0, 1'b0, 17'h0, 32'h0);
        repeat (2) @(negedge clk);
        checks++; if (bus3.ready_sram !== 1'b1 || bus3.mem_oe !== 1'b0) begin errors++;
            $display("FAIL rst_held: got ready=%b oe=%b want 1/0", bus3.ready_sram, bus3.mem_oe);
        end
        reset_n = 1'b1;
        start(1'b0, 1'b0, 17'h1FFFF, 32'h0);
        finish(1'b0, 1'b0, 17'h1FFFF, 32'h0, low);
        exp = exp_q.pop_front();
        checks++; if (bus3.data_sram !== exp) begin errors++;
            $display("FAIL rst_write_discarded: got %h want %h", bus3.data_sram, exp); end
        release_req(1'b0);
    endtask

    task automatic test_rw_conflict();
        int low;
        logic [31:0] exp;
        start(1'b0, 1'b1, 17'h00010, 32'h0);
        finish(1'b0, 1'b1, 17'h00010, 32'h0, low);
        release_req(1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 17'h00010, 32'hA5A5A5A5);
        #1;
        checks++; if (bus3.mem_oe !== 1'b0) begin errors++;
            $display("FAIL rw_no_contention: drive enable got %b want 0", bus3.mem_oe); end
        @(negedge clk);
`ifdef MAIN_MEM_RW_ERR_EN
        checks++; if (bus3.err_sram !== 1'b1 || bus3.ready_sram !== 1'b1) begin errors++;
            $display("FAIL rw_err_pulse: got err=%b ready=%b want 1/1", bus3.err_sram,
                     bus3.ready_sram); end
        drive(1'b0, 1'b0, 1'b0, 17'h0, 32'h0);
        @(negedge clk);
        checks++; if (bus3.err_sram !== 1'b0 || bus3.ready_sram !== 1'b1) begin errors++;
            $display("FAIL rw_err_one_cycle: got err=%b ready=%b want 0/1", bus3.err_sram,
                     bus3.ready_sram); end
`else
        checks++; if (bus3.err_sram !== 1'b0 || bus3.ready_sram !== 1'b0) begin errors++;
            $display("FAIL rw_as_write: got err=%b ready=%b want 0/0", bus3.err_sram,
                     bus3.ready_sram); end
        // Dropping the request mid-access must not disturb it.
        drive(1'b0, 1'b0, 1'b0, 17'h0, 32'h0);
        low = 1;
        @(negedge clk);
        while (bus3.ready_sram !== 1'b1 && low < 50) begin
            low++;
            @(negedge clk);
        end
        checks++; if (low !== 3) begin errors++;
            $display("FAIL rw_latency: ready low %0d cycles want 3", low); end
        model[key(1'b0, 17'h00010)] = 32'hA5A5A5A5;
        @(negedge clk);
`endif
        start(1'b0, 1'b0, 17'h00010, 32'h0);
        finish(1'b0, 1'b0, 17'h00010, 32'h0, low);
        exp = exp_q.pop_front();
        checks++; if (bus3.data_sram !== exp) begin errors++;
            $display("FAIL rw_readback: got %h want %h", bus3.data_sram, exp); end
        release_req(1'b0);
    endtask

    task automatic test_back_to_back();
        int low;
        logic [31:0] exp;
        logic [16:0] addrs [2];
        logic [31:0] datas [2];
        addrs[0] = 17'h00001; addrs[1] = 17'h00002;
        datas[0] = 32'h01010101; datas[1] = 32'h02020202;
        for (int i = 0; i < 2; i++) begin
            start(1'b1, 1'b1, addrs[i], datas[i]);
            finish(1'b1, 1'b1, addrs[i], datas[i], low);
            release_req(1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            start(1'b1, 1'b0, addrs[i], 32'h0);
            finish(1'b1, 1'b0, addrs[i], 32'h0, low);
            exp = exp_q.pop_front();
            checks++; if (low !== 1 || bus1.data_sram !== exp) begin errors++;
                $display("FAIL b2b_read %0d: got low=%0d data=%h want 1/%h", i, low,
                         bus1.data_sram, exp); end
            release_req(1'b1);
        end
        start(1'b1, 1'b1, addrs[0], 32'h0F0F0F0F);
        #1;
        checks++; if (bus1.mem_oe !== 1'b0 || bus1.data_sram !== 32'h0F0F0F0F) begin errors++;
            $display("FAIL b2b_contention: got oe=%b data=%h want 0/0f0f0f0f", bus1.mem_oe,
                     bus1.data_sram); end
        finish(1'b1, 1'b1, addrs[0], 32'h0F0F0F0F, low);
        checks++; if (low !== 1) begin errors++;
            $display("FAIL b2b_wr_latency: ready low %0d cycles want 1", low); end
        release_req(1'b1);
        start(1'b1, 1'b0, addrs[0], 32'h0);
        finish(1'b1, 1'b0, addrs[0], 32'h0, low);
        exp = exp_q.pop_front();
        checks++; if (bus1.data_sram !== exp) begin errors++;
            $display("FAIL b2b_overwrite: got %h want %h", bus1.data_sram, exp); end
        release_req(1'b1);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hold();
        test_reset_busy();
        test_rw_conflict();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
